// File: rtl/shift_add_mul_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
// The optional GF reduction step is enabled by SHIFT_ADD_MUL_GF_REDUCE_EN.
package shift_add_mul_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;

   localparam logic MODE_INT   = 1'b1;
   localparam logic MODE_CLMUL = 1'b0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      REDUCE = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/shift_add_mul_mul_step_add.sv
// Single add step of the multiplier: integer add with carry, or carry-less XOR.
module mul_step_add #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_option_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_out_o
);

   logic [WIDTH:0] full_sum;

   always_comb begin
      full_sum = {1'b0, a_i} + {1'b0, b_i};
      if (carry_option_i) begin
         sum_o       = full_sum[WIDTH-1:0];
         carry_out_o = full_sum[WIDTH];
      end else begin
         sum_o       = a_i ^ b_i;
         carry_out_o = 1'b0;
      end
   end

endmodule

// File: rtl/shift_add_mul.sv
// Iterative WIDTH-step shift-and-add multiplier, integer or carry-less GF(2) mode.
// Defining SHIFT_ADD_MUL_GF_REDUCE_EN adds the poly port and the REDUCE state.
module shift_add_mul
   import shift_add_mul_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               carry_option,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
`ifdef SHIFT_ADD_MUL_GF_REDUCE_EN
   input  logic [WIDTH-1:0]   poly,
`endif
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic                 mode_q, mode_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [WIDTH-1:0]     add_sum;
   logic                 add_carry;
   logic [WIDTH-1:0]     step_hi;
   logic                 step_c;

   mul_step_add #(
      .WIDTH (WIDTH)
   ) u_step_add (
      .a_i            (hi_q),
      .b_i            (a_q),
      .carry_option_i (mode_q),
      .sum_o          (add_sum),
      .carry_out_o    (add_carry)
   );

`ifdef SHIFT_ADD_MUL_GF_REDUCE_EN
   logic [2*WIDTH-1:0] red_poly;
   logic [2*WIDTH-1:0] red_probe;
   // x^WIDTH + poly with its leading term sitting on the product MSB.
   assign red_poly  = {1'b1, poly, {(WIDTH-1){1'b0}}};
   assign red_probe = product_q << cnt_q;
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      a_d       = a_q;
      mode_d    = mode_q;
      product_d = product_q;
      step_c    = 1'b0;
      step_hi   = hi_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d     = a;
               mode_d  = carry_option;
               hi_d    = '0;
               lo_d    = b;
               cnt_d   = '0;
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (lo_q[0]) begin
               step_c  = add_carry;
               step_hi = add_sum;
            end
            hi_d  = {step_c, step_hi[WIDTH-1:1]};
            lo_d  = {step_hi[0], lo_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               product_d = {hi_d, lo_d};
               cnt_d     = '0;
               state_d   = DONE;
`ifdef SHIFT_ADD_MUL_GF_REDUCE_EN
               if (mode_q == MODE_CLMUL) begin
                  state_d = REDUCE;
               end
`endif
            end
         end
`ifdef SHIFT_ADD_MUL_GF_REDUCE_EN
         REDUCE: begin
            // Step k clears product bit 2*WIDTH-1-k.
            if (red_probe[2*WIDTH-1]) begin
               product_d = product_q ^ (red_poly >> cnt_q);
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_STEP) begin
               cnt_d   = '0;
               state_d = DONE;
            end
         end
`endif
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         a_q       <= '0;
         mode_q    <= MODE_INT;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         a_q       <= a_d;
         mode_q    <= mode_d;
         product_q <= product_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign product   = product_q;

endmodule

// File: tb/tb_shift_add_mul.sv
// Self-checking bench for shift_add_mul against an arithmetic reference model.
// Build with SHIFT_ADD_MUL_GF_REDUCE_EN to also exercise the reduction step.
module tb_shift_add_mul;

   localparam int W = 32;
   localparam int LAT_INT = W + 1;
`ifdef SHIFT_ADD_MUL_GF_REDUCE_EN
   localparam int LAT_CL = 2 * W + 1;
`else
   localparam int LAT_CL = W + 1;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_ready;
   logic           carry_option = 1'b1;
   logic [W-1:0]   a = '0;
   logic [W-1:0]   b = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [2*W-1:0] product;
`ifdef SHIFT_ADD_MUL_GF_REDUCE_EN
   logic [W-1:0]   poly = 32'h0000_008D;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_add_mul #(
      .WIDTH (W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .carry_option (carry_option),
      .a            (a),
      .b            (b),
`ifdef SHIFT_ADD_MUL_GF_REDUCE_EN
      .poly         (poly),
`endif
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .product      (product)
   );

   // Reference model: schoolbook polynomial product and long division over GF(2).
   function automatic logic [2*W-1:0] clmul_ref(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] r = '0;
      for (int i = 0; i < W; i++)
         if (y[i]) r = r ^ ({{W{1'b0}}, x} << i);
      return r;
   endfunction

   function automatic logic [2*W-1:0] gf_mod(input logic [2*W-1:0] p, input logic [W-1:0] pl);
      logic [2*W-1:0] m = {{(W-1){1'b0}}, 1'b1, pl};
      for (int i = 2 * W - 1; i >= W; i--)
         if (p[i]) p = p ^ (m << (i - W));
      return p;
   endfunction

   function automatic logic [2*W-1:0] expect_prod(input logic [W-1:0] x, input logic [W-1:0] y,
                                                   input logic mode, input logic [W-1:0] pl);
      logic [2*W-1:0] r;
      if (mode) begin
         r = 64'(x) * 64'(y);
      end else begin
         r = clmul_ref(x, y);
`ifdef SHIFT_ADD_MUL_GF_REDUCE_EN
         r = gf_mod(r, pl);
`endif
      end
      return r;
   endfunction

   function automatic logic [W-1:0] cur_poly();
`ifdef SHIFT_ADD_MUL_GF_REDUCE_EN
      return poly;
`else
      return '0;
`endif
   endfunction

   // Drives one op from IDLE (called #1 after an edge); lat counts edges from accept to out_valid.
   task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic mode,
                         output logic [2*W-1:0] prod, output int lat);
      a = ia;
      b = ib;
      carry_option = mode;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!out_valid) lat = -1;
      prod = product;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", in_ready);
      end
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out_valid got %b want 0", out_valid);
      end
      checks++;
      if (product !== '0) begin
         errors++;
         $display("FAIL reset_product got %h want 0", product);
      end
   endtask

   task automatic test_directed();
      logic [W-1:0]   ta[5] = '{32'hFFFF_FFFF, 32'd3, 32'd3, 32'hFFFF_FFFF, 32'd0};
      logic [W-1:0]   tb[5] = '{32'hFFFF_FFFF, 32'd3, 32'd3, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
      logic           tm[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [2*W-1:0] want[5];
      logic [2*W-1:0] got;
      int lat;
      want[0] = 64'hFFFF_FFFE_0000_0001;
      want[1] = 64'h9;
      want[2] = expect_prod(32'd3, 32'd3, 1'b0, cur_poly());
      want[3] = expect_prod(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cur_poly());
      want[4] = 64'h0;
`ifndef SHIFT_ADD_MUL_GF_REDUCE_EN
      want[2] = 64'h5;
      want[3] = 64'h5555_5555_5555_5555;
`endif
      for (int i = 0; i < 5; i++) begin
         run_op(ta[i], tb[i], tm[i], got, lat);
         checks++;
         if (got !== want[i]) begin
            errors++;
            $display("FAIL directed_%0d_product got %h want %h", i, got, want[i]);
         end
         checks++;
         if (lat != (tm[i] ? LAT_INT : LAT_CL)) begin
            errors++;
            $display("FAIL directed_%0d_latency got %0d want %0d", i, lat,
                     tm[i] ? LAT_INT : LAT_CL);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0]   ra, rb;
      logic           rm;
      logic [2*W-1:0] got, want;
      int lat;
      for (int i = 0; i < 24; i++) begin
         ra = $urandom();
         rb = $urandom();
         rm = 1'($urandom_range(0, 1));
         if (i % 8 == 0) ra = '1;
         if (i % 8 == 1) rb = 32'h8000_0000;
`ifdef SHIFT_ADD_MUL_GF_REDUCE_EN
         poly = $urandom();
`endif
         want = expect_prod(ra, rb, rm, cur_poly());
         run_op(ra, rb, rm, got, lat);
         checks++;
         if (got !== want || lat != (rm ? LAT_INT : LAT_CL)) begin
            errors++;
            $display("FAIL random_%0d a=%h b=%h mode=%b got %h lat %0d want %h lat %0d",
                     i, ra, rb, rm, got, lat, want, rm ? LAT_INT : LAT_CL);
         end
      end
`ifdef SHIFT_ADD_MUL_GF_REDUCE_EN
      poly = 32'h0000_008D;
`endif
   endtask

   task automatic test_backpressure();
      logic [2*W-1:0] got, want;
      logic [2*W-1:0] held;
      int lat;
      int bad = 0;
      a = 32'h0001_2345;
      b = 32'h0000_0777;
      carry_option = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      held = product;
      checks++;
      if (held !== 64'h0001_2345 * 64'h777) begin
         errors++;
         $display("FAIL bp_product got %h want %h", held, 64'h0001_2345 * 64'h777);
      end
      a = 32'hAAAA_AAAA;
      b = 32'h5555_5555;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (product !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      in_valid = 1'b0;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_hold %0d cycles disturbed want 0", bad);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_release in_ready %b out_valid %b want 1 0", in_ready, out_valid);
      end
      want = 64'h0000_0000_F0F0 * 64'h0000_0000_0101;
      run_op(32'h0000_F0F0, 32'h0000_0101, 1'b1, got, lat);
      checks++;
      if (got !== want || lat != LAT_INT) begin
         errors++;
         $display("FAIL bp_next got %h lat %0d want %h lat %0d", got, lat, want, LAT_INT);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      a = 32'h0000_0011;
      b = 32'h0000_0022;
      carry_option = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (!out_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      // New operands presented together with the output handshake.
      a = 32'h0000_1001;
      b = 32'h0000_0003;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL b2b_no_accept_in_done in_ready got %b want 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 300) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (product !== 64'h3003 || lat != LAT_INT) begin
         errors++;
         $display("FAIL b2b_product got %h lat %0d want %h lat %0d", product, lat, 64'h3003,
                  LAT_INT);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_busy();
      logic [2*W-1:0] got;
      int lat;
      int seen = 0;
      a = 32'hFFFF_0000;
      b = 32'h1234_5678;
      carry_option = 1'b1;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== '0) begin
         errors++;
         $display("FAIL rst_busy in_ready %b out_valid %b product %h want 1 0 0", in_ready,
                  out_valid, product);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL rst_busy_no_valid got %0d valid cycles want 0", seen);
      end
      run_op(32'h0000_1234, 32'h0000_0010, 1'b1, got, lat);
      checks++;
      if (got !== 64'h12340 || lat != LAT_INT) begin
         errors++;
         $display("FAIL rst_busy_next got %h lat %0d want %h lat %0d", got, lat, 64'h12340,
                  LAT_INT);
      end
   endtask

`ifdef SHIFT_ADD_MUL_GF_REDUCE_EN
   task automatic test_reduce();
      logic [2*W-1:0] got;
      int lat;
      poly = 32'h0000_008D;
      run_op(32'h8000_0000, 32'h2, 1'b0, got, lat);
      checks++;
      if (got !== 64'h8D || lat != 65) begin
         errors++;
         $display("FAIL reduce_clmul got %h lat %0d want %h lat 65", got, lat, 64'h8D);
      end
      run_op(32'h8000_0000, 32'h2, 1'b1, got, lat);
      checks++;
      if (got !== 64'h1_0000_0000 || lat != 33) begin
         errors++;
         $display("FAIL reduce_int got %h lat %0d want %h lat 33", got, lat, 64'h1_0000_0000);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid_busy();
`ifdef SHIFT_ADD_MUL_GF_REDUCE_EN
      test_reduce();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/shift_add_mul.md
# shift_add_mul

- Iterative shift-and-add multiplier for WIDTH-bit operands.
- Two arithmetic modes, selected per operation by `carry_option`: integer multiply (carries propagate) or carry-less GF(2) polynomial multiply (carries suppressed, additions are XOR).
- Sits downstream of the team's operand path. Each accepted operand pair is consumed over WIDTH cycles through a single WIDTH-bit add step, which is the same adder behaviour the adder-comparison blocks implement.
- Returns a 2·WIDTH-bit product over a valid/ready handshake.

## Interface
- WIDTH, 32, operand width; product is 2·WIDTH bits; WIDTH ≥ 2.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair and mode present.
- in_ready  output  1  block can accept; high only in IDLE.
- carry_option  input  1  1 = integer multiply, 0 = carry-less multiply; sampled at accept.
- a  input  WIDTH  multiplicand; sampled at accept.
- b  input  WIDTH  multiplier; sampled at accept.
- out_valid  output  1  product valid; high only in DONE.
- out_ready  input  1  consumer takes product.
- product  output  2·WIDTH  result register.
- poly  input  WIDTH  low terms of reduction polynomial x^WIDTH + poly. Present only with SHIFT_ADD_MUL_GF_REDUCE_EN.

## Operation
- States: IDLE → BUSY → (REDUCE) → DONE → IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: latch a, b, carry_option; clear accumulator {c, hi, lo} with lo←b; counter←0; go to BUSY.
- BUSY, one step per cycle:
  - If lo[0]=1: {c, hi} ← hi + a. Integer mode gives a WIDTH+1-bit sum; carry-less mode gives c=0 and hi ^ a.
  - Otherwise {c, hi} ← {0, hi}.
  - Then shift {c, hi, lo} right by 1 and increment the counter.
  - After step WIDTH−1: go to DONE, or to REDUCE if the macro is enabled and the mode is carry-less. product ← {hi, lo} is loaded on the state exit.
- REDUCE (macro only): see Configuration.
- DONE:
  - out_valid=1; product is held stable.
  - Leave to IDLE on out_ready.
  - in_valid is ignored; no back-to-back accept in the same cycle as the output handshake.
- in_valid while not IDLE: ignored, and no operand is latched.
- Integer result is exact: unsigned a·b, no overflow possible in 2·WIDTH bits.
- Counter width is clog2(WIDTH)+1. The step count never wraps.

## Timing
- Reset values: in_ready=1 once reset deasserts, out_valid=0, product=0, state=IDLE, counter=0, accumulator=0.
- Accept at edge 0. BUSY occupies edges 1..WIDTH. out_valid rises after edge WIDTH, giving a latency of WIDTH+1 cycles (33 at WIDTH=32).
- With the reduction step, latency is 2·WIDTH+1 cycles.
- Throughput: one operation per WIDTH+2 cycles minimum (accept cycle, WIDTH steps, one DONE cycle with out_ready=1).
- out_valid stays high indefinitely until out_ready.
- rst asserted in any state, including mid-BUSY or mid-REDUCE: immediate return to IDLE with reset values. The partial result is discarded and no out_valid pulse is produced.
- in_valid and out_ready both high in DONE: the output handshake completes, and the input is not accepted until the next cycle in IDLE.

## Configuration
- Macro: SHIFT_ADD_MUL_GF_REDUCE_EN.
- Defined:
  - The `poly` port exists.
  - Carry-less operations enter REDUCE for WIDTH cycles. Each cycle processes one product bit from 2·WIDTH−1 down to WIDTH: if that bit is set, XOR (x^WIDTH + poly) aligned so its leading term cancels that bit.
  - After REDUCE: product[2·WIDTH−1:WIDTH]=0 and product[WIDTH−1:0] = a·b mod P.
  - Integer mode is unchanged.
- Undefined:
  - There is no `poly` port and no REDUCE state.
  - Carry-less mode returns the full unreduced 2·WIDTH-bit product.

## Structure
- Package `shift_add_mul_pkg`:
  - state enum (IDLE, BUSY, REDUCE, DONE);
  - default WIDTH constant;
  - mode encoding constants MODE_INT=1, MODE_CLMUL=0.
- One sub-module, `mul_step_add`: combinational WIDTH-bit adder with carry_option input, returning {carry_out, sum}. It propagates carries when carry_option=1 and outputs a^b with carry_out=0 when carry_option=0.
- The FSM, counter, accumulator shifter and reduction logic live in `shift_add_mul`.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, product=0.
- Integer, a=0xFFFFFFFF, b=0xFFFFFFFF → product=0xFFFFFFFE00000001, out_valid exactly 33 cycles after accept. Also a=3, b=3 → 0x9.
- Carry-less, a=3, b=3 → 0x5. a=0xFFFFFFFF, b=0xFFFFFFFF → 0x5555555555555555. Integer result with a=0 → 0.
- Backpressure: out_ready held low 10 cycles in DONE → product and out_valid stable, in_ready=0, a concurrent in_valid with new operands is ignored; raise out_ready → IDLE next cycle and the next op is accepted correctly.
- rst pulsed at BUSY step 10 → state IDLE, outputs at reset values, no out_valid. A subsequent integer op 0x1234×0x10 gives 0x12340.
- Macro defined, carry-less, poly=0x0000008D, a=0x80000000, b=0x2 → product=0x000000000000008D after 65 cycles. The same operands in integer mode give 0x100000000 after 33 cycles.
